fmac_writeback: RTL and testbench

FMAC_WRITEBACK -- requirements
Module: fmac_writeback

---
 rtl/fmac_pkg.sv | 21 ++
 rtl/fmac_result_fifo.sv | 69 ++++++
 rtl/fmac_writeback.sv | 126 ++++++++++++
 tb/tb_fmac_writeback.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fmac_pkg.sv
// Shared constants for the FMAC writeback stage.
//   PARM_EXP / PARM_MANT : default IEEE single-precision field widths
//   NAN_MANT             : canonical quiet-NaN mantissa at the default width
//   FLAG_*               : bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
package fmac_pkg;

  localparam int unsigned PARM_EXP  = 8;
  localparam int unsigned PARM_MANT = 23;

  // Quiet NaN: only the mantissa MSB set.
  localparam logic [PARM_MANT-1:0] NAN_MANT = {1'b1, {(PARM_MANT-1){1'b0}}};

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned FLAG_W = 5;

endpackage

// File: rtl/fmac_result_fifo.sv
// Small synchronous result queue.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   push, wdata   : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry, stable until popped
//   full, empty   : derived from the occupancy counter
//   count         : occupancy, 0..Depth
module fmac_result_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is intentionally not reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fmac_writeback.sv
// FMAC writeback stage: packs rounded results, computes per-result IEEE flags,
// buffers them in a small queue and accrues flags when results commit.
//   clk, rst                    : clock, synchronous active-high reset
//   In_valid_i / In_ready_o     : rounder handshake (ready = queue not full)
//   Sign_i, Exp_i, Mant_i       : rounded fields
//   Invalid_i .. Inexact_i      : rounder exception flags
//   Rd_i                        : destination register tag
//   Out_valid_o / Out_ready_i   : register-file handshake
//   Result_o, Rd_o, Fflags_o    : head-of-queue result, tag and flags
//   Fflags_clr_i, Fflags_acc_o  : clear / view of accrued flags
//   Count_o                     : queue occupancy
module fmac_writeback #(
  parameter int unsigned PARM_EXP      = fmac_pkg::PARM_EXP,
  parameter int unsigned PARM_MANT     = fmac_pkg::PARM_MANT,
  parameter int unsigned PARM_RD_WIDTH = 5,
  parameter int unsigned PARM_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic [PARM_MANT-1:0]          Mant_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  input  logic                          Inexact_i,
  input  logic [PARM_RD_WIDTH-1:0]      Rd_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [PARM_RD_WIDTH-1:0]      Rd_o,
  output logic [4:0]                    Fflags_o,
  input  logic                          Fflags_clr_i,
  output logic [4:0]                    Fflags_acc_o,
  output logic [$clog2(PARM_DEPTH):0]   Count_o
);

  import fmac_pkg::*;

  localparam int unsigned ResW   = 1 + PARM_EXP + PARM_MANT;
  localparam int unsigned EntryW = FLAG_W + PARM_RD_WIDTH + ResW;

  logic [ResW-1:0]   in_result;
  logic [FLAG_W-1:0] in_flags;
  logic [EntryW-1:0] in_entry, head_entry;
  logic [FLAG_W-1:0] head_flags;
  logic              full, empty, push, pop;
  logic              exp_ones, of_eff, nx_eff;
  logic [FLAG_W-1:0] acc_q, acc_d;

  // ---------------------------------------------------------------------------
  // Packing and per-result flags, evaluated at push time
  // ---------------------------------------------------------------------------
  assign exp_ones = &Exp_i;
  // Overflow is not reported for an invalid op or for a NaN-encoded result.
  assign of_eff   = Overflow_i & ~Invalid_i & (~exp_ones | (Mant_i == '0));
  assign nx_eff   = Inexact_i | of_eff;

  always_comb begin
    in_flags          = '0;
    in_flags[FLAG_NV] = Invalid_i;
    in_flags[FLAG_DZ] = 1'b0;
    in_flags[FLAG_OF] = of_eff;
    in_flags[FLAG_UF] = Underflow_i & nx_eff;
    in_flags[FLAG_NX] = nx_eff;
  end

  always_comb begin
    if (Invalid_i) begin
      in_result = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
    end else begin
      in_result = {Sign_i, Exp_i, Mant_i};
    end
  end

  assign in_entry = {in_flags, Rd_i, in_result};

  // ---------------------------------------------------------------------------
  // Result queue
  // ---------------------------------------------------------------------------
  assign In_ready_o  = ~full;
  assign Out_valid_o = ~empty;
  assign push        = In_valid_i & In_ready_o;
  assign pop         = Out_valid_o & Out_ready_i;

  fmac_result_fifo #(
    .Width (EntryW),
    .Depth (PARM_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (full),
    .empty (empty),
    .count (Count_o)
  );

  assign head_flags = head_entry[EntryW-1 -: FLAG_W];
  assign Fflags_o   = head_flags;
  assign Rd_o       = head_entry[ResW +: PARM_RD_WIDTH];
  assign Result_o   = head_entry[ResW-1:0];

  // ---------------------------------------------------------------------------
  // Accrued flags: committed at pop; a pop coincident with a clear survives.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = Fflags_clr_i ? '0 : acc_q;
    if (pop) acc_d = acc_d | head_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Fflags_acc_o = acc_q;

endmodule

// File: tb/tb_fmac_writeback.sv
module tb_fmac_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sign;
  logic [7:0]  exp_f;
  logic [22:0] mant;
  logic        nv, ovf, unf, nx;
  logic [4:0]  rd;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out, fflags, fflags_acc;
  logic        fflags_clr;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [4:0]  fl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fmac_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .In_valid_i   (in_valid),
    .In_ready_o   (in_ready),
    .Sign_i       (sign),
    .Exp_i        (exp_f),
    .Mant_i       (mant),
    .Invalid_i    (nv),
    .Overflow_i   (ovf),
    .Underflow_i  (unf),
    .Inexact_i    (nx),
    .Rd_i         (rd),
    .Out_valid_o  (out_valid),
    .Out_ready_i  (out_ready),
    .Result_o     (result),
    .Rd_o         (rd_out),
    .Fflags_o     (fflags),
    .Fflags_clr_i (fflags_clr),
    .Fflags_acc_o (fflags_acc),
    .Count_o      (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one item; caller is at posedge+1. Returns at posedge+1 after acceptance.
  task automatic push_item(input logic s, input logic [7:0] e, input logic [22:0] m,
                           input logic i_nv, input logic i_of, input logic i_uf,
                           input logic i_nx, input logic [4:0] i_rd,
                           input logic [31:0] x_res, input logic [4:0] x_fl,
                           input bit track);
    bit   ok = 0;
    exp_t x;
    sign = s; exp_f = e; mant = m; nv = i_nv; ovf = i_of; unf = i_uf; nx = i_nx; rd = i_rd;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0, expected 1 within 50 cycles");
    end else if (track) begin
      x.res = x_res; x.rd = i_rd; x.fl = x_fl;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid & ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got result 0x%0h rd %0d, expected no output", result,
                 rd_out);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("out_result", 64'(result), 64'(x.res));
        check("out_rd", 64'(rd_out), 64'(x.rd));
        check("out_fflags", 64'(fflags), 64'(x.fl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    sign = 0; exp_f = 0; mant = 0; nv = 0; ovf = 0; unf = 0; nx = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_count", 64'(count), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_acc", 64'(fflags_acc), 64'd0);

    // Plain result, one-cycle latency.
    out_ready = 1'b1;
    push_item(1'b0, 8'h7F, 23'h0, 0, 0, 0, 0, 5'd3, 32'h3F80_0000, 5'b00000, 1);
    check("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Invalid -> canonical NaN; flags accrue at pop, not push.
    push_item(1'b1, 8'hFF, 23'h123, 1, 0, 0, 0, 5'd7, 32'h7FC0_0000, 5'b10000, 1);
    check("acc_not_at_push", 64'(fflags_acc), 64'd0);
    @(posedge clk); #1;
    check("acc_after_nv_pop", 64'(fflags_acc), 64'b10000);
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    check("acc_cleared", 64'(fflags_acc), 64'd0);

    // Flag derivation corner cases.
    push_item(1'b0, 8'hFF, 23'h0, 0, 1, 0, 0, 5'd1, 32'h7F80_0000, 5'b00101, 1);
    push_item(1'b0, 8'h01, 23'h5, 0, 0, 1, 0, 5'd2, 32'h0080_0005, 5'b00000, 1);
    push_item(1'b0, 8'hFF, 23'h1, 0, 1, 0, 0, 5'd4, 32'h7F80_0001, 5'b00000, 1);
    push_item(1'b1, 8'h00, 23'h3, 0, 0, 1, 1, 5'd5, 32'h8000_0003, 5'b00011, 1);
    repeat (2) @(posedge clk); #1;
    check("acc_of_uf_nx", 64'(fflags_acc), 64'b00111);

    // Clear coincident with an NX pop keeps the popped flag.
    out_ready = 1'b0;
    push_item(1'b0, 8'h80, 23'h0, 0, 0, 0, 1, 5'd6, 32'h4000_0000, 5'b00001, 1);
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    check("acc_clr_with_pop", 64'(fflags_acc), 64'b00001);

    // Backpressure: two accepted, third waits for a pop.
    out_ready = 1'b0;
    push_item(1'b1, 8'h7F, 23'h400000, 0, 0, 0, 0, 5'd8, 32'hBFC0_0000, 5'b00000, 1);
    push_item(1'b0, 8'h81, 23'h200000, 0, 0, 0, 1, 5'd9, 32'h40A0_0000, 5'b00001, 1);
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    fork
      push_item(1'b0, 8'h82, 23'h0, 0, 0, 0, 0, 5'd10, 32'h4100_0000, 5'b00000, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("held_count", 64'(count), 64'd2);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    check("drained_count", 64'(count), 64'd0);

    // Simultaneous push and pop leaves occupancy unchanged.
    out_ready = 1'b0;
    push_item(1'b0, 8'h01, 23'h0, 0, 0, 0, 0, 5'd11, 32'h0080_0000, 5'b00000, 1);
    out_ready = 1'b1;
    push_item(1'b0, 8'h02, 23'h0, 0, 0, 0, 0, 5'd12, 32'h0100_0000, 5'b00000, 1);
    check("push_pop_count", 64'(count), 64'd1);
    repeat (2) @(posedge clk); #1;

    // Reset mid-operation discards entries and accrued flags.
    out_ready = 1'b0;
    push_item(1'b0, 8'h00, 23'h0, 1, 0, 0, 0, 5'd13, 32'h0, 5'b0, 0);
    push_item(1'b0, 8'hFF, 23'h0, 0, 1, 0, 1, 5'd14, 32'h0, 5'b0, 0);
    check("pre_reset_count", 64'(count), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_count", 64'(count), 64'd0);
    check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    check("mid_reset_acc", 64'(fflags_acc), 64'd0);
    check("mid_reset_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("no_stale_output", 64'(out_valid), 64'd0);
    check("post_reset_acc", 64'(fflags_acc), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
